// File: rtl/uart_rx_mmio_pkg.sv
// Shared constants for the UART receiver: bus widths, IO offsets, RXSTAT bit map and FSM states.
// The optional interrupt logic in uart_rx_mmio is enabled by defining UART_RX_IRQ_EN.
`ifndef UART_DIV
`define UART_DIV 16
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h0000_1000
`endif
`ifndef IO_UART_RX_OFFSET
`define IO_UART_RX_OFFSET 32'h0000_0008
`endif
`ifndef IO_UART_RXSTAT_OFFSET
`define IO_UART_RXSTAT_OFFSET 32'h0000_000C
`endif

package uart_rx_mmio_pkg;
  localparam int XLEN             = `XLEN;
  localparam int ADDR_W           = `ADDR_W;
  localparam int UART_DIV_DEFAULT = `UART_DIV;

  localparam logic [ADDR_W-1:0] RXDATA_ADDR = ADDR_W'(`IO_BASE_ADDR + `IO_UART_RX_OFFSET);
  localparam logic [ADDR_W-1:0] RXSTAT_ADDR = ADDR_W'(`IO_BASE_ADDR + `IO_UART_RXSTAT_OFFSET);

  localparam int STAT_NE      = 0;
  localparam int STAT_OVR     = 1;
  localparam int STAT_FERR    = 2;
  localparam int STAT_FULL    = 3;
  localparam int STAT_IRQ_EN  = 8;
  localparam int STAT_CNT_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_rx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO. A push into a full FIFO succeeds only when a pop frees
// the slot in the same cycle; otherwise the word is dropped and drop_o pulses.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic             drop_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && !push_ok;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with an RX FIFO behind RXDATA/RXSTAT MMIO registers.
// Define UART_RX_IRQ_EN to add the irq output and the RW irq_en bit in RXSTAT.
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter int UART_DIV   = UART_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mmio_req,
  input  logic              mmio_we,
  input  logic [ADDR_W-1:0] mmio_addr,
  input  logic [XLEN-1:0]   mmio_wdata,
  output logic [XLEN-1:0]   mmio_rdata,
  output logic              mmio_ready,
  input  logic              uart_rx
`ifdef UART_RX_IRQ_EN
  ,
  output logic              irq
`endif
);
  localparam int CNT_W = $clog2(UART_DIV);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(UART_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(UART_DIV / 2 - 1);

  logic           sync1_q, rx_s_q;
  uart_rx_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]     bit_idx_q;
  logic [7:0]     shift_q;
  logic           brk_q, push_q, ferr_set_q;

  logic [7:0]     fifo_head;
  logic           fifo_full, fifo_empty, fifo_drop;
  logic [CW-1:0]  fifo_count;

  logic [XLEN-1:0] rdata_q, rdata_d, stat_w;
  logic            ovr_q, ovr_d, ferr_q, ferr_d, irq_en;
  logic            rd, wr, hit_data, hit_stat, pop;
  logic            unused_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      rx_s_q  <= sync1_q;
    end
  end

  // brk_q holds the FSM in IDLE after a framing error until the line returns high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      brk_q      <= 1'b0;
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (brk_q) begin
            if (rx_s_q) brk_q <= 1'b0;
          end else if (!rx_s_q) begin
            state_q <= ST_START;
            cnt_q   <= HALF_RELOAD;
          end
        end
        ST_START: begin
          if (cnt_q == '0) begin
            if (!rx_s_q) begin
              state_q   <= ST_DATA;
              cnt_q     <= BIT_RELOAD;
              bit_idx_q <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (cnt_q == '0) begin
            shift_q[bit_idx_q] <= rx_s_q;
            cnt_q              <= BIT_RELOAD;
            if (bit_idx_q == 3'd7) state_q <= ST_STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        ST_STOP: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            if (rx_s_q) begin
              push_q <= 1'b1;
            end else begin
              ferr_set_q <= 1'b1;
              brk_q      <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .pop_i   (pop),
    .wdata_i (shift_q),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .drop_o  (fifo_drop)
  );

  // mmio_req is the valid; mmio_ready mirrors it, so each request completes in the cycle it is presented.
  assign mmio_ready = mmio_req;
  assign mmio_rdata = rdata_q;
  assign rd         = mmio_req && !mmio_we;
  assign wr         = mmio_req && mmio_we;
  assign hit_data   = (mmio_addr == RXDATA_ADDR);
  assign hit_stat   = (mmio_addr == RXSTAT_ADDR);
  assign pop        = rd && hit_data && !fifo_empty;
  assign unused_wdata = ^mmio_wdata;

  always_comb begin
    stat_w                            = '0;
    stat_w[STAT_NE]                   = !fifo_empty;
    stat_w[STAT_OVR]                  = ovr_q;
    stat_w[STAT_FERR]                 = ferr_q;
    stat_w[STAT_FULL]                 = fifo_full;
    stat_w[STAT_IRQ_EN]               = irq_en;
    stat_w[STAT_CNT_LSB +: CW]        = fifo_count;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      if (hit_data)      rdata_d = fifo_empty ? '0 : XLEN'(fifo_head);
      else if (hit_stat) rdata_d = stat_w;
      else               rdata_d = '0;
    end
  end

  // A set in the same cycle as a write-1-to-clear wins.
  always_comb begin
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (wr && hit_stat && mmio_wdata[STAT_OVR])  ovr_d  = 1'b0;
    if (wr && hit_stat && mmio_wdata[STAT_FERR]) ferr_d = 1'b0;
    if (fifo_drop)  ovr_d  = 1'b1;
    if (ferr_set_q) ferr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr && hit_stat) irq_en_d = mmio_wdata[STAT_IRQ_EN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_en_q && (!fifo_empty || ovr_q);
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio: frames on uart_rx, MMIO reads checked against a byte-queue model.
// The irq checks are compiled in when UART_RX_IRQ_EN is defined.
module tb_uart_rx_mmio;
  import uart_rx_mmio_pkg::*;

  localparam int DIV   = 16;
  localparam int DEPTH = 4;
  // Edge (counted from the start-bit edge) at which a received byte lands in the FIFO:
  // 2 synchroniser stages + detect, half a bit to the centre, 9 bit periods, 1 registered push.
  localparam int PUSH_EDGE = 3 + DIV / 2 + 9 * DIV + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mmio_req = 1'b0;
  logic              mmio_we = 1'b0;
  logic [ADDR_W-1:0] mmio_addr = '0;
  logic [XLEN-1:0]   mmio_wdata = '0;
  logic [XLEN-1:0]   mmio_rdata;
  logic              mmio_ready;
  logic              uart_rx = 1'b1;
`ifdef UART_RX_IRQ_EN
  logic              irq;
`endif

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] exp_q[$];
  logic            rd_done = 1'b0;

  // Model state: received bytes in order, sticky flags, interrupt enable.
  logic [7:0] mq[$];
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_irq_en = 1'b0;

  uart_rx_mmio #(
    .UART_DIV   (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mmio_req   (mmio_req),
    .mmio_we    (mmio_we),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .mmio_rdata (mmio_rdata),
    .mmio_ready (mmio_ready),
    .uart_rx    (uart_rx)
`ifdef UART_RX_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model
  function automatic logic [XLEN-1:0] model_stat();
    logic [XLEN-1:0] s;
    s = XLEN'(mq.size()) * 65536;
    if (mq.size() != 0)     s = s + 1;
    if (m_ovr)              s = s + 2;
    if (m_ferr)             s = s + 4;
    if (mq.size() == DEPTH) s = s + 8;
    if (m_irq_en)           s = s + 256;
    return s;
  endfunction

  function automatic logic [XLEN-1:0] model_read(input logic [ADDR_W-1:0] addr);
    if (addr == RXDATA_ADDR) begin
      if (mq.size() == 0) return '0;
      return XLEN'(mq.pop_front());
    end
    if (addr == RXSTAT_ADDR) return model_stat();
    return '0;
  endfunction

  function automatic void model_write(input logic [ADDR_W-1:0] addr, input logic [XLEN-1:0] d);
    if (addr == RXSTAT_ADDR) begin
      if (d[1]) m_ovr = 1'b0;
      if (d[2]) m_ferr = 1'b0;
`ifdef UART_RX_IRQ_EN
      m_irq_en = d[8];
`endif
    end
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (mq.size() == DEPTH) m_ovr = 1'b1;
    else                    mq.push_back(b);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovr    = 1'b0;
    m_ferr   = 1'b0;
    m_irq_en = 1'b0;
  endfunction

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] addr);
    exp_q.push_back(model_read(addr));
    mmio_req  = 1'b1;
    mmio_we   = 1'b0;
    mmio_addr = addr;
    tick();
    mmio_req  = 1'b0;
  endtask

  task automatic bus_read_lit(input string name, input logic [ADDR_W-1:0] addr, input logic [XLEN-1:0] lit);
    chk({"model ", name}, model_read(addr), lit);
    exp_q.push_back(lit);
    mmio_req  = 1'b1;
    mmio_we   = 1'b0;
    mmio_addr = addr;
    tick();
    mmio_req  = 1'b0;
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] addr, input logic [XLEN-1:0] d);
    model_write(addr, d);
    mmio_req   = 1'b1;
    mmio_we    = 1'b1;
    mmio_addr  = addr;
    mmio_wdata = d;
    tick();
    mmio_req   = 1'b0;
    mmio_we    = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low);
    uart_rx = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) tick();
    end
    uart_rx = stop;
    repeat (DIV) tick();
    if (stop) begin
      model_push(b);
    end else begin
      repeat (extra_low) tick();
      uart_rx = 1'b1;
      repeat (4) tick();
      m_ferr = 1'b1;
    end
  endtask

  // Scoreboard: every completed read is checked the following falling edge.
  always @(posedge clk) rd_done <= mmio_req && !mmio_we;

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready", XLEN'(mmio_ready), XLEN'(mmio_req));
      if (rd_done) begin
        if (exp_q.size() == 0) chk("rdata unexpected read", mmio_rdata, 'x);
        else                   chk("rdata", mmio_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset rdata", mmio_rdata, 32'h0);
    bus_read_lit("reset stat", RXSTAT_ADDR, 32'h0);
    bus_read_lit("empty data", RXDATA_ADDR, 32'h0);

    // Single byte
    send_frame(8'hA5, 1'b1, 0);
    repeat (4) tick();
    bus_read_lit("one byte stat", RXSTAT_ADDR, 32'h0001_0001);
    bus_write(RXDATA_ADDR, 32'hFF);
    bus_read_lit("one byte data", RXDATA_ADDR, 32'h0000_00A5);
    bus_read_lit("drained stat", RXSTAT_ADDR, 32'h0);
    bus_read_lit("unmapped", RXDATA_ADDR + 32'h40, 32'h0);

    // Glitch rejection
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (24) tick();
    chk("glitch fsm idle", XLEN'(dut.state_q), XLEN'(ST_IDLE));
    bus_read_lit("glitch stat", RXSTAT_ADDR, 32'h0);

    // Frame error followed by a clean byte
    send_frame(8'h3C, 1'b0, 40);
    bus_read_lit("frame err stat", RXSTAT_ADDR, 32'h0000_0004);
    send_frame(8'h11, 1'b1, 0);
    repeat (4) tick();
    bus_read(RXSTAT_ADDR);
    bus_read(RXDATA_ADDR);
    bus_write(RXSTAT_ADDR, 32'h4);
    bus_read_lit("ferr cleared", RXSTAT_ADDR, 32'h0);

    // Overrun and pointer wrap
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
    repeat (4) tick();
    bus_read_lit("overrun stat", RXSTAT_ADDR, 32'h0004_000B);
    for (int i = 0; i < 4; i++) bus_read(RXDATA_ADDR);
    bus_write(RXSTAT_ADDR, 32'h106);
    bus_read(RXSTAT_ADDR);
    for (int i = 6; i <= 9; i++) send_frame(8'(i), 1'b1, 0);
    repeat (4) tick();
    bus_read(RXSTAT_ADDR);
    for (int i = 0; i < 4; i++) bus_read(RXDATA_ADDR);
    bus_write(RXSTAT_ADDR, 32'h0);

    // Full FIFO, pop on the same edge as the push
    for (int i = 0; i < 4; i++) send_frame(8'h21 + 8'(i), 1'b1, 0);
    fork
      send_frame(8'h25, 1'b1, 0);
      begin
        repeat (PUSH_EDGE - 1) tick();
        bus_read(RXDATA_ADDR);
      end
    join
    repeat (4) tick();
    bus_read_lit("pop push stat", RXSTAT_ADDR, 32'h0004_0009);
    for (int i = 0; i < 4; i++) bus_read(RXDATA_ADDR);
    bus_read(RXSTAT_ADDR);

`ifdef UART_RX_IRQ_EN
    bus_write(RXSTAT_ADDR, 32'h100);
    bus_read_lit("irq_en stat", RXSTAT_ADDR, 32'h0000_0100);
    fork
      send_frame(8'h5A, 1'b1, 0);
      begin
        repeat (PUSH_EDGE) tick();
        chk("irq at push", XLEN'(irq), 32'h0);
        tick();
        chk("irq after push", XLEN'(irq), 32'h1);
      end
    join
    bus_read(RXDATA_ADDR);
    chk("irq held on pop edge", XLEN'(irq), 32'h1);
    tick();
    chk("irq after pop", XLEN'(irq), 32'h0);
    send_frame(8'h44, 1'b1, 0);
    repeat (4) tick();
    chk("irq pending", XLEN'(irq), 32'h1);
`endif

    // Reset in the middle of a frame
    send_frame(8'h77, 1'b1, 0);
    uart_rx = 1'b0;
    repeat (DIV) tick();
    uart_rx = 1'b1;
    repeat (DIV) tick();
    uart_rx = 1'b0;
    repeat (18) tick();
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    tick();
`ifdef UART_RX_IRQ_EN
    chk("irq after reset", XLEN'(irq), 32'h0);
`endif
    repeat (DIV * 10) tick();
    bus_read_lit("stat after reset", RXSTAT_ADDR, 32'h0);
    send_frame(8'h66, 1'b1, 0);
    repeat (4) tick();
    bus_read(RXSTAT_ADDR);
    bus_read_lit("byte after reset", RXDATA_ADDR, 32'h0000_0066);

    repeat (3) tick();
    chk("scoreboard drained", XLEN'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
